// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port synchronous RAM between the VGA
// display scan (absolute priority) and a level-request pixel writer.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int AW       = 19,
  parameter int DW       = 3
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          Ready_Sig,
  input  logic [10:0]   Column_Addr_Sig,
  input  logic [9:0]    Row_Addr_Sig,
  input  logic          HSYNC_In,
  input  logic          VSYNC_In,
  input  logic          Wr_Req,
  input  logic [AW-1:0] Wr_Addr,
  input  logic [DW-1:0] Wr_Data,
  output logic          Wr_Ack,
  output logic          Wr_Err,
  output logic [AW-1:0] Mem_Addr,
  output logic          Mem_Wr_En,
  output logic [DW-1:0] Mem_Wr_Data,
  input  logic [DW-1:0] Mem_Rd_Data,
  output logic [DW-1:0] Pixel_Data,
  output logic          HSYNC_Out,
  output logic          VSYNC_Out
);

  localparam logic [AW:0] FB_SIZE = (AW+1)'(H_ACTIVE * V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic          accept_s;
  logic          in_range_s;
  logic [AW-1:0] disp_addr_s;
  logic          ready_d1_r;
  logic          ready_d2_r;
  logic [1:0]    hs_pipe_r;
  logic [1:0]    vs_pipe_r;

  assign disp_addr_s = AW'(Row_Addr_Sig) * AW'(H_ACTIVE) + AW'(Column_Addr_Sig);
  assign in_range_s  = ({1'b0, Wr_Addr} < FB_SIZE);

  // Writer FSM state register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Writer FSM next state; a request is only accepted while the display is idle
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (Wr_Req && !Ready_Sig) begin
          state_next_s = WRITE;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        state_next_s = RELEASE;
      end
      RELEASE: begin
        // Wait for the level request to drop so it is acknowledged only once
        if (!Wr_Req) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RELEASE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // RAM port registers, write handshake and sticky range error
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      Mem_Addr    <= {AW{1'b0}};
      Mem_Wr_En   <= 1'b0;
      Mem_Wr_Data <= {DW{1'b0}};
      Wr_Ack      <= 1'b0;
      Wr_Err      <= 1'b0;
    end else begin
      Wr_Ack <= accept_s;
      if (Ready_Sig) begin
        Mem_Addr  <= disp_addr_s;
        Mem_Wr_En <= 1'b0;
      end else if (accept_s) begin
        Mem_Addr    <= Wr_Addr;
        Mem_Wr_En   <= in_range_s;
        Mem_Wr_Data <= Wr_Data;
      end else begin
        Mem_Wr_En <= 1'b0;
      end
      if (accept_s && !in_range_s) begin
        Wr_Err <= 1'b1;
      end
    end
  end

  // Three-stage display pipeline: address, RAM read, pixel; syncs follow in lockstep
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ready_d1_r <= 1'b0;
      ready_d2_r <= 1'b0;
      Pixel_Data <= {DW{1'b0}};
      hs_pipe_r  <= 2'b00;
      vs_pipe_r  <= 2'b00;
      HSYNC_Out  <= 1'b0;
      VSYNC_Out  <= 1'b0;
    end else begin
      ready_d1_r <= Ready_Sig;
      ready_d2_r <= ready_d1_r;
      Pixel_Data <= ready_d2_r ? Mem_Rd_Data : {DW{1'b0}};
      hs_pipe_r  <= {hs_pipe_r[0], HSYNC_In};
      vs_pipe_r  <= {vs_pipe_r[0], VSYNC_In};
      HSYNC_Out  <= hs_pipe_r[1];
      VSYNC_Out  <= vs_pipe_r[1];
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a behavioural synchronous RAM whose
// read data is a fixed function of the address (addr[2:0] ^ 3'b010).
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready = 1'b0;
  logic [10:0] col = 11'd0;
  logic [9:0]  row = 10'd0;
  logic        hs_in = 1'b0;
  logic        vs_in = 1'b0;
  logic        wr_req = 1'b0;
  logic [18:0] wr_addr = 19'd0;
  logic [2:0]  wr_data = 3'd0;
  logic        wr_ack;
  logic        wr_err;
  logic [18:0] mem_addr;
  logic        mem_wr_en;
  logic [2:0]  mem_wr_data;
  logic [2:0]  mem_rd_data = 3'd0;
  logic [2:0]  pixel;
  logic        hs_out;
  logic        vs_out;

  int tests = 0;
  int fails = 0;
  int ack_cnt;
  int we_cnt;
  int bad_cnt;

  vga_fb_arbiter dut (
    .CLK(clk), .RST_n(rst_n), .Ready_Sig(ready),
    .Column_Addr_Sig(col), .Row_Addr_Sig(row),
    .HSYNC_In(hs_in), .VSYNC_In(vs_in),
    .Wr_Req(wr_req), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Wr_Ack(wr_ack), .Wr_Err(wr_err),
    .Mem_Addr(mem_addr), .Mem_Wr_En(mem_wr_en), .Mem_Wr_Data(mem_wr_data),
    .Mem_Rd_Data(mem_rd_data),
    .Pixel_Data(pixel), .HSYNC_Out(hs_out), .VSYNC_Out(vs_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem_addr[2:0] ^ 3'b010;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_err", 32'(wr_err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_we", 32'(mem_wr_en), 32'd0);
    check("rst_wdata", 32'(mem_wr_data), 32'd0);
    check("rst_pix", 32'(pixel), 32'd0);
    check("rst_sync", 32'({hs_out, vs_out}), 32'd0);
    rst_n = 1'b1;
    step();

    // Display read at row 2, col 5: address 1605, RAM data 1605[2:0]^2 = 7
    ready = 1'b1; row = 10'd2; col = 11'd5;
    step();
    check("rd_addr", 32'(mem_addr), 32'd1605);
    check("rd_we", 32'(mem_wr_en), 32'd0);
    ready = 1'b0;
    step();
    check("rd_pix_t2", 32'(pixel), 32'd0);
    check("rd_hold_addr", 32'(mem_addr), 32'd1605);
    step();
    check("rd_pix_t3", 32'(pixel), 32'd7);
    step();
    check("rd_pix_t4", 32'(pixel), 32'd0);

    // Held request: one ack, one write strobe
    wr_req = 1'b1; wr_addr = 19'd100; wr_data = 3'd5;
    ack_cnt = 0; we_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (wr_ack) ack_cnt++;
      if (mem_wr_en) begin
        we_cnt++;
        if (mem_addr != 19'd100 || mem_wr_data != 3'd5) bad_cnt++;
      end
    end
    check("hold_acks", 32'(ack_cnt), 32'd1);
    check("hold_wes", 32'(we_cnt), 32'd1);
    check("hold_wr_fields", 32'(bad_cnt), 32'd0);
    wr_req = 1'b0;
    step();
    wr_req = 1'b1; wr_addr = 19'd200; wr_data = 3'd3;
    step();
    check("rearm_ack", 32'(wr_ack), 32'd1);
    check("rearm_addr", 32'(mem_addr), 32'd200);
    check("rearm_wdata", 32'(mem_wr_data), 32'd3);
    step();
    check("rearm_ack_drop", 32'({wr_ack, mem_wr_en}), 32'd0);
    wr_req = 1'b0;
    step();

    // Request blocked for a full display line, granted once the line ends
    ready = 1'b1; row = 10'd1; wr_req = 1'b1; wr_addr = 19'd300; wr_data = 3'd6;
    ack_cnt = 0; we_cnt = 0; bad_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      col = 11'(i);
      step();
      if (wr_ack) ack_cnt++;
      if (mem_wr_en) we_cnt++;
      if (mem_addr != 19'(800 + i)) bad_cnt++;
    end
    check("blk_acks", 32'(ack_cnt), 32'd0);
    check("blk_wes", 32'(we_cnt), 32'd0);
    check("blk_rd_addrs", 32'(bad_cnt), 32'd0);
    ready = 1'b0;
    step();
    check("blk_grant_ack", 32'(wr_ack), 32'd1);
    check("blk_grant_we", 32'(mem_wr_en), 32'd1);
    check("blk_grant_addr", 32'(mem_addr), 32'd300);
    wr_req = 1'b0;
    step();
    step();
    check("err_clear", 32'(wr_err), 32'd0);

    // Out-of-range write: acked, no strobe, sticky error
    wr_req = 1'b1; wr_addr = 19'd480000; wr_data = 3'd1;
    step();
    check("oor_ack", 32'(wr_ack), 32'd1);
    check("oor_we", 32'(mem_wr_en), 32'd0);
    check("oor_err", 32'(wr_err), 32'd1);
    wr_req = 1'b0;
    step();
    step();
    wr_req = 1'b1; wr_addr = 19'd479999;
    step();
    check("last_ok_we", 32'(mem_wr_en), 32'd1);
    check("err_sticky", 32'(wr_err), 32'd1);
    wr_req = 1'b0;
    step();
    step();

    // Sync delay: vsync 5-cycle pulse, hsync 1-cycle pulse, both 3 cycles late
    for (int i = 0; i < 12; i++) begin
      vs_in = (i < 5);
      hs_in = (i == 3);
      step();
      check($sformatf("vs_dly%0d", i), 32'(vs_out), 32'((i >= 2) && (i < 7)));
      check($sformatf("hs_dly%0d", i), 32'(hs_out), 32'(i == 5));
    end

    // Asynchronous reset while a write is on the RAM port
    wr_req = 1'b1; wr_addr = 19'd50; wr_data = 3'd4;
    step();
    check("pre_rst_we", 32'(mem_wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(mem_wr_en), 32'd0);
    check("arst_ack", 32'(wr_ack), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'd0);
    check("arst_wdata", 32'(mem_wr_data), 32'd0);
    check("arst_err", 32'(wr_err), 32'd0);
    wr_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_ack", 32'({wr_ack, mem_wr_en}), 32'd0);
    wr_req = 1'b1; wr_addr = 19'd10; wr_data = 3'd2;
    step();
    check("post_rst_idle_ack", 32'(wr_ack), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'd10);
    wr_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
